dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 202 ++++++++++++++++++++
 tb/tb_dma_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller: single-channel memory-to-memory DMA that copies one byte per read/write beat pair.
// Optional completion interrupt storage is built only when DMA_CONTROLLER_IRQ_EN is defined.
`timescale 1ns/1ps
module dma_controller #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CFG_WE,
  input  logic [2:0]               CFG_SEL,
  input  logic [7:0]               CFG_D,
  output logic [ADDRESS_WIDTH-1:0] D1_ADDR,
  output logic                     D1_RW,
  output logic                     D1_RQ,
  input  logic                     D1_OK,
  output logic [DATA_WIDTH-1:0]    DMA_DOUT,
  input  logic [DATA_WIDTH-1:0]    DMA_DIN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     IRQ
);

  localparam logic [2:0] SEL_SRC_L = 3'd0;
  localparam logic [2:0] SEL_SRC_H = 3'd1;
  localparam logic [2:0] SEL_DST_L = 3'd2;
  localparam logic [2:0] SEL_DST_H = 3'd3;
  localparam logic [2:0] SEL_LEN_L = 3'd4;
  localparam logic [2:0] SEL_LEN_H = 3'd5;
  localparam logic [2:0] SEL_CTRL  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] src_q, src_d;
  logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
  logic [15:0]              len_q, len_d;
  logic [DATA_WIDTH-1:0]    buf_q, buf_d;
  logic                     done_q, done_d;

  logic isIdle;
  logic ctrlWrite;
  logic startCmd;
  logic abortCmd;
  logic readDone;
  logic beatDone;
  logic lastBeat;
  logic lenZero;

  assign isIdle    = (state_q == IDLE);
  assign ctrlWrite = CFG_WE && (CFG_SEL == SEL_CTRL);
  assign startCmd  = isIdle && ctrlWrite && CFG_D[0];
  // Abort beats a simultaneous bus completion, so it gates every beat update below.
  assign abortCmd  = !isIdle && ctrlWrite && CFG_D[1];
  assign readDone  = (state_q == RD) && D1_OK && !abortCmd;
  assign beatDone  = (state_q == WR) && D1_OK && !abortCmd;
  assign lenZero   = (len_q == 16'd0);
  assign lastBeat  = beatDone && (len_q == 16'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startCmd && !lenZero) begin
          state_d = RD;
        end
      end
      RD: begin
        if (abortCmd) begin
          state_d = IDLE;
        end else if (D1_OK) begin
          state_d = WR;
        end
      end
      WR: begin
        if (abortCmd) begin
          state_d = IDLE;
        end else if (D1_OK) begin
          state_d = (len_q == 16'd1) ? IDLE : RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    D1_RQ   = 1'b0;
    D1_RW   = 1'b1;
    D1_ADDR = '0;
    BUSY    = 1'b0;
    case (state_q)
      RD: begin
        D1_RQ   = 1'b1;
        D1_ADDR = src_q;
        BUSY    = 1'b1;
      end
      WR: begin
        D1_RQ   = 1'b1;
        D1_RW   = 1'b0;
        D1_ADDR = dst_q;
        BUSY    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    buf_d  = buf_q;
    done_d = done_q;
    if (isIdle && CFG_WE) begin
      case (CFG_SEL)
        SEL_SRC_L: src_d[7:0]               = CFG_D;
        SEL_SRC_H: src_d[ADDRESS_WIDTH-1:8] = CFG_D[ADDRESS_WIDTH-9:0];
        SEL_DST_L: dst_d[7:0]               = CFG_D;
        SEL_DST_H: dst_d[ADDRESS_WIDTH-1:8] = CFG_D[ADDRESS_WIDTH-9:0];
        SEL_LEN_L: len_d[7:0]               = CFG_D;
        SEL_LEN_H: len_d[15:8]              = CFG_D;
        default: ;
      endcase
    end
    // A zero-length start completes immediately; otherwise start clears the sticky flag.
    if (startCmd) begin
      done_d = lenZero;
    end
    if (readDone) begin
      buf_d = DMA_DIN;
    end
    if (beatDone) begin
      src_d = src_q + 1'b1;
      dst_d = dst_q + 1'b1;
      len_d = len_q - 16'd1;
    end
    if (lastBeat) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      buf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      buf_q  <= buf_d;
      done_q <= done_d;
    end
  end

  assign DMA_DOUT = buf_q;
  assign DONE     = done_q;

`ifdef DMA_CONTROLLER_IRQ_EN
  logic irq_q, irq_d;
  logic irqSet;

  assign irqSet = (startCmd && lenZero) || lastBeat;

  // Setting wins over an acknowledge landing on the same edge.
  always_comb begin
    irq_d = irq_q;
    if (ctrlWrite && CFG_D[2]) begin
      irq_d = 1'b0;
    end
    if (irqSet) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed DMA scenarios; bus beats are checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_dma_controller;

`ifdef DMA_CONTROLLER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        CFG_WE;
  logic [2:0]  CFG_SEL;
  logic [7:0]  CFG_D;
  logic [15:0] D1_ADDR;
  logic        D1_RW;
  logic        D1_RQ;
  logic        D1_OK;
  logic [7:0]  DMA_DOUT;
  logic [7:0]  DMA_DIN;
  logic        BUSY;
  logic        DONE;
  logic        IRQ;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } busTxn_t;

  busTxn_t expQ[$];
  busTxn_t monExp;
  int checks = 0;
  int errors = 0;

  dma_controller #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CFG_WE(CFG_WE),
    .CFG_SEL(CFG_SEL),
    .CFG_D(CFG_D),
    .D1_ADDR(D1_ADDR),
    .D1_RW(D1_RW),
    .D1_RQ(D1_RQ),
    .D1_OK(D1_OK),
    .DMA_DOUT(DMA_DOUT),
    .DMA_DIN(DMA_DIN),
    .BUSY(BUSY),
    .DONE(DONE),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // Memory model: every byte reads back as its low address byte XOR 0xA5.
  assign DMA_DIN = D1_ADDR[7:0] ^ 8'hA5;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data);
    CFG_WE  = 1'b1;
    CFG_SEL = sel;
    CFG_D   = data;
    tick(1);
    CFG_WE  = 1'b0;
    CFG_SEL = 3'd0;
    CFG_D   = 8'd0;
  endtask

  task automatic setupXfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    applyStimulus(3'd0, src[7:0]);
    applyStimulus(3'd1, src[15:8]);
    applyStimulus(3'd2, dst[7:0]);
    applyStimulus(3'd3, dst[15:8]);
    applyStimulus(3'd4, len[7:0]);
    applyStimulus(3'd5, len[15:8]);
  endtask

  task automatic pushTxn(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    busTxn_t t;
    t.rw   = rw;
    t.addr = addr;
    t.data = data;
    expQ.push_back(t);
  endtask

  // Monitor: every granted bus beat must match the next expected transaction.
  always @(negedge CLK) begin
    if (D1_RQ === 1'b1 && D1_OK === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bus_unexpected: got rw=%0b addr=0x%0h, expected no bus beat", D1_RW, D1_ADDR);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("bus_rw", 32'(D1_RW), 32'(monExp.rw));
        checkOutput("bus_addr", 32'(D1_ADDR), 32'(monExp.addr));
        if (!monExp.rw) begin
          checkOutput("bus_wdata", 32'(DMA_DOUT), 32'(monExp.data));
        end
      end
    end
  end

  initial begin
    RST     = 1'b1;
    CFG_WE  = 1'b0;
    CFG_SEL = 3'd0;
    CFG_D   = 8'd0;
    D1_OK   = 1'b1;
    tick(2);
    RST = 1'b0;
    checkOutput("rst_rq", 32'(D1_RQ), 32'd0);
    checkOutput("rst_rw", 32'(D1_RW), 32'd1);
    checkOutput("rst_addr", 32'(D1_ADDR), 32'd0);
    checkOutput("rst_dout", 32'(DMA_DOUT), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_done", 32'(DONE), 32'd0);
    checkOutput("rst_irq", 32'(IRQ), 32'd0);

    $display("[TB] zero-length start");
    applyStimulus(3'd6, 8'h01);
    checkOutput("len0_done", 32'(DONE), 32'd1);
    checkOutput("len0_busy", 32'(BUSY), 32'd0);
    checkOutput("len0_irq", 32'(IRQ), 32'(IRQ_EN));
    for (int i = 0; i < 3; i++) begin
      checkOutput("len0_rq", 32'(D1_RQ), 32'd0);
      tick(1);
    end
    applyStimulus(3'd6, 8'h04);
    checkOutput("len0_irq_ack", 32'(IRQ), 32'd0);

    $display("[TB] three-byte copy");
    setupXfer(16'h1000, 16'h2000, 16'd3);
    pushTxn(1'b1, 16'h1000, 8'hA5);
    pushTxn(1'b0, 16'h2000, 8'hA5);
    pushTxn(1'b1, 16'h1001, 8'hA4);
    pushTxn(1'b0, 16'h2001, 8'hA4);
    pushTxn(1'b1, 16'h1002, 8'hA7);
    pushTxn(1'b0, 16'h2002, 8'hA7);
    applyStimulus(3'd6, 8'h01);
    checkOutput("copy_start_clears_done", 32'(DONE), 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("copy_rq_continuous", 32'(D1_RQ), 32'd1);
      tick(1);
    end
    checkOutput("copy_done", 32'(DONE), 32'd1);
    checkOutput("copy_busy", 32'(BUSY), 32'd0);
    checkOutput("copy_rq_idle", 32'(D1_RQ), 32'd0);
    checkOutput("copy_irq", 32'(IRQ), 32'(IRQ_EN));
    checkOutput("copy_drained", 32'(expQ.size()), 32'd0);
    applyStimulus(3'd6, 8'h04);

    $display("[TB] restart continues from final pointers");
    applyStimulus(3'd4, 8'h01);
    pushTxn(1'b1, 16'h1003, 8'hA6);
    pushTxn(1'b0, 16'h2003, 8'hA6);
    applyStimulus(3'd6, 8'h01);
    checkOutput("restart_done_clear", 32'(DONE), 32'd0);
    checkOutput("restart_busy", 32'(BUSY), 32'd1);
    tick(2);
    checkOutput("restart_done", 32'(DONE), 32'd1);
    applyStimulus(3'd6, 8'h04);

    $display("[TB] address wrap");
    setupXfer(16'hFFFF, 16'h7FFF, 16'd2);
    pushTxn(1'b1, 16'hFFFF, 8'h5A);
    pushTxn(1'b0, 16'h7FFF, 8'h5A);
    pushTxn(1'b1, 16'h0000, 8'hA5);
    pushTxn(1'b0, 16'h8000, 8'hA5);
    applyStimulus(3'd6, 8'h01);
    tick(4);
    checkOutput("wrap_done", 32'(DONE), 32'd1);
    applyStimulus(3'd6, 8'h04);

    $display("[TB] wait states in read");
    D1_OK = 1'b0;
    setupXfer(16'h0040, 16'h0080, 16'd1);
    applyStimulus(3'd6, 8'h01);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wait_addr", 32'(D1_ADDR), 32'h0040);
      checkOutput("wait_rw", 32'(D1_RW), 32'd1);
      checkOutput("wait_rq", 32'(D1_RQ), 32'd1);
      tick(1);
    end
    pushTxn(1'b1, 16'h0040, 8'hE5);
    pushTxn(1'b0, 16'h0080, 8'hE5);
    D1_OK = 1'b1;
    tick(2);
    checkOutput("wait_done", 32'(DONE), 32'd1);
    applyStimulus(3'd6, 8'h04);

    $display("[TB] abort on second write");
    setupXfer(16'h0100, 16'h0200, 16'd5);
    pushTxn(1'b1, 16'h0100, 8'hA5);
    pushTxn(1'b0, 16'h0200, 8'hA5);
    pushTxn(1'b1, 16'h0101, 8'hA4);
    pushTxn(1'b0, 16'h0201, 8'hA4);
    applyStimulus(3'd6, 8'h01);
    tick(3);
    checkOutput("abort_in_wr", 32'(D1_RW), 32'd0);
    applyStimulus(3'd6, 8'h02);
    checkOutput("abort_busy", 32'(BUSY), 32'd0);
    checkOutput("abort_rq", 32'(D1_RQ), 32'd0);
    checkOutput("abort_done", 32'(DONE), 32'd0);
    checkOutput("abort_irq", 32'(IRQ), 32'd0);
    pushTxn(1'b1, 16'h0101, 8'hA4);
    pushTxn(1'b0, 16'h0201, 8'hA4);
    pushTxn(1'b1, 16'h0102, 8'hA7);
    pushTxn(1'b0, 16'h0202, 8'hA7);
    pushTxn(1'b1, 16'h0103, 8'hA6);
    pushTxn(1'b0, 16'h0203, 8'hA6);
    pushTxn(1'b1, 16'h0104, 8'hA1);
    pushTxn(1'b0, 16'h0204, 8'hA1);
    applyStimulus(3'd6, 8'h01);
    tick(7);
    checkOutput("resume_not_done", 32'(DONE), 32'd0);
    checkOutput("resume_busy", 32'(BUSY), 32'd1);
    tick(1);
    checkOutput("resume_done", 32'(DONE), 32'd1);
    applyStimulus(3'd6, 8'h04);

    $display("[TB] reset during write");
    setupXfer(16'h0300, 16'h0400, 16'd3);
    pushTxn(1'b1, 16'h0300, 8'hA5);
    pushTxn(1'b0, 16'h0400, 8'hA5);
    applyStimulus(3'd6, 8'h01);
    tick(1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checkOutput("midrst_rq", 32'(D1_RQ), 32'd0);
    checkOutput("midrst_rw", 32'(D1_RW), 32'd1);
    checkOutput("midrst_addr", 32'(D1_ADDR), 32'd0);
    checkOutput("midrst_dout", 32'(DMA_DOUT), 32'd0);
    checkOutput("midrst_busy", 32'(BUSY), 32'd0);
    checkOutput("midrst_done", 32'(DONE), 32'd0);
    checkOutput("midrst_irq", 32'(IRQ), 32'd0);
    applyStimulus(3'd0, 8'h55);
    applyStimulus(3'd2, 8'h66);
    applyStimulus(3'd4, 8'h01);
    pushTxn(1'b1, 16'h0055, 8'hF0);
    pushTxn(1'b0, 16'h0066, 8'hF0);
    applyStimulus(3'd6, 8'h01);
    tick(2);
    checkOutput("postrst_done", 32'(DONE), 32'd1);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
